// File: rtl/within_stim_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : within_stim_pkg
//  Purpose  : Shared types and constants for the within/throughout stimulus
//             generator: FSM state encoding and the default field width.
//  Revision : 1.0  initial release
// ============================================================================
package within_stim_pkg;

   // Default width of every length, offset and index field
   localparam int CNT_W_DEF = 4;

   // Sequencer states, explicit 2-bit encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      TRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : within_stim_pkg
`default_nettype wire

// File: rtl/within_stim_gen_if.sv
`default_nettype none
// ============================================================================
//  Interface : within_stim_gen_if
//  Purpose   : Bundles the request/config inputs and stimulus/status outputs
//              of within_stim_gen.
//  Ports     : start, train_len, bus_off, bus_len, inj_en, inj_idx (requester
//              to generator); transport, bus, train, busy, done, cfg_err
//              (generator to requester/checker).
//  Modports  : master - requester side, slave - generator side.
//  Revision  : 1.0  initial release
// ============================================================================
interface within_stim_gen_if #(
   parameter int CNT_W = within_stim_pkg::CNT_W_DEF
);
   logic             start;
   logic [CNT_W-1:0] train_len;
   logic [CNT_W-1:0] bus_off;
   logic [CNT_W-1:0] bus_len;
   logic             inj_en;
   logic [CNT_W-1:0] inj_idx;

   logic             transport;
   logic             bus;
   logic             train;
   logic             busy;
   logic             done;
   logic             cfg_err;

   modport master (
      output start, train_len, bus_off, bus_len, inj_en, inj_idx,
      input  transport, bus, train, busy, done, cfg_err
   );

   modport slave (
      input  start, train_len, bus_off, bus_len, inj_en, inj_idx,
      output transport, bus, train, busy, done, cfg_err
   );

endinterface : within_stim_gen_if
`default_nettype wire

// File: rtl/within_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : within_stim_gen
//  Purpose  : Generates one transport/train/bus window sequence per accepted
//             start: a one-cycle LEAD (transport only), train_len TRAIN cycles
//             with bus inside a configurable sub-window and an optional
//             single-cycle transport dropout, then a one-cycle DONE pulse.
//  Ports    : clk  - clock, all logic on rising edge
//             rst  - synchronous active-high reset
//             sif  - within_stim_gen_if.slave (request, config, stimulus,
//                    busy/done/cfg_err status)
//  Note     : CNT_W must match the CNT_W of the connected interface.
//  Revision : 1.0  initial release
// ============================================================================
module within_stim_gen
   import within_stim_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  wire logic        clk,
   input  wire logic        rst,
   within_stim_gen_if.slave sif
);

   state_t           state;
   logic [CNT_W-1:0] idx;

   // Configuration captured at the accepted start
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] off_q;
   logic [CNT_W:0]   end_q;      // bus_off + bus_len, one bit wider
   logic             inj_en_q;
   logic [CNT_W-1:0] inj_idx_q;

   // Registered outputs
   logic transport_r;
   logic bus_r;
   logic train_r;
   logic busy_r;
   logic done_r;
   logic cfg_err_r;

   // Start validation; the sum is one bit wider so it cannot wrap
   logic [CNT_W:0] cfg_end;
   logic           cfg_bad;

   assign cfg_end = {1'b0, sif.bus_off} + {1'b0, sif.bus_len};
   assign cfg_bad = (sif.train_len == '0) || (sif.bus_len == '0) ||
                    (cfg_end > {1'b0, sif.train_len});

   // Index that the next TRAIN cycle will display; LEAD seeds it with 0.
   // idx never exceeds train_len-1, so idx+1 cannot wrap.
   logic [CNT_W-1:0] idx_nxt;
   logic             last_cyc;
   logic             bus_nxt;
   logic             trans_nxt;

   assign idx_nxt   = (state == LEAD) ? '0 : idx + 1'b1;
   assign last_cyc  = (state == TRAIN) && (idx == len_q - 1'b1);
   assign bus_nxt   = (idx_nxt >= off_q) && ({1'b0, idx_nxt} < end_q);
   // An inj_idx at or beyond train_len is never reached, so no dropout occurs
   assign trans_nxt = !(inj_en_q && (idx_nxt == inj_idx_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         len_q       <= '0;
         off_q       <= '0;
         end_q       <= '0;
         inj_en_q    <= 1'b0;
         inj_idx_q   <= '0;
         transport_r <= 1'b0;
         bus_r       <= 1'b0;
         train_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cfg_err_r   <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (sif.start) begin
                  if (cfg_bad) begin
                     cfg_err_r <= 1'b1;
                  end else begin
                     len_q       <= sif.train_len;
                     off_q       <= sif.bus_off;
                     end_q       <= cfg_end;
                     inj_en_q    <= sif.inj_en;
                     inj_idx_q   <= sif.inj_idx;
                     state       <= LEAD;
                     transport_r <= 1'b1;
                     busy_r      <= 1'b1;
                  end
               end
            end
            LEAD, TRAIN: begin
               if (last_cyc) begin
                  state       <= DONE;
                  transport_r <= 1'b0;
                  bus_r       <= 1'b0;
                  train_r     <= 1'b0;
                  done_r      <= 1'b1;
               end else begin
                  state       <= TRAIN;
                  idx         <= idx_nxt;
                  train_r     <= 1'b1;
                  bus_r       <= bus_nxt;
                  transport_r <= trans_nxt;
               end
            end
            DONE: begin
               // start is not looked at here; the first IDLE cycle samples it
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign sif.transport = transport_r;
   assign sif.bus       = bus_r;
   assign sif.train     = train_r;
   assign sif.busy      = busy_r;
   assign sif.done      = done_r;
   assign sif.cfg_err   = cfg_err_r;

endmodule : within_stim_gen
`default_nettype wire

// File: tb/tb_within_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_within_stim_gen
//  Purpose  : Self-checking bench for within_stim_gen. Each start pushes the
//             expected per-cycle output vectors {transport,bus,train,busy,
//             done,cfg_err} into a queue; every cycle one entry is popped and
//             compared with the DUT outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_within_stim_gen;
   import within_stim_pkg::*;

   localparam int W = CNT_W_DEF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   within_stim_gen_if #(.CNT_W(W)) sif ();

   within_stim_gen #(.CNT_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .sif (sif)
   );

   typedef logic [5:0] vec_t;   // {transport,bus,train,busy,done,cfg_err}

   vec_t  exp_q[$];
   string tag_q[$];
   int    n_assert = 0;
   int    n_fail   = 0;

   function automatic vec_t mk(bit tr, bit bu, bit tn, bit by, bit dn, bit ce);
      return {tr, bu, tn, by, dn, ce};
   endfunction

   task automatic push(vec_t v, string tag);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   // Expected cycles k = 1 .. len+3 after the start cycle, truncated at max_k
   task automatic push_seq(int len, int off, int blen, bit en, int iidx,
                           int max_k, string tag);
      for (int k = 1; k <= len + 3 && k <= max_k; k++) begin
         if (k == 1) begin
            push(mk(1, 0, 0, 1, 0, 0), {tag, "_lead"});
         end else if (k <= len + 1) begin
            int  i  = k - 2;
            bit  bu = (i >= off) && (i < off + blen);
            bit  tr = !(en && (i == iidx));
            push(mk(tr, bu, 1, 1, 0, 0), $sformatf("%s_i%0d", tag, i));
         end else if (k == len + 2) begin
            push(mk(0, 0, 0, 1, 1, 0), {tag, "_done"});
         end else begin
            push(mk(0, 0, 0, 0, 0, 0), {tag, "_idle"});
         end
      end
   endtask

   task automatic push_reject(string tag);
      push(mk(0, 0, 0, 0, 0, 1), {tag, "_err"});
      push(mk(0, 0, 0, 0, 0, 0), {tag, "_idle"});
   endtask

   task automatic drive_cfg(int len, int off, int blen, bit en, int iidx);
      sif.train_len = W'(len);
      sif.bus_off   = W'(off);
      sif.bus_len   = W'(blen);
      sif.inj_en    = en;
      sif.inj_idx   = W'(iidx);
   endtask

   task automatic step();
      vec_t  obs;
      vec_t  ex;
      string tag;
      @(posedge clk);
      #1;
      obs = {sif.transport, sif.bus, sif.train, sif.busy, sif.done, sif.cfg_err};
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL no_expectation: observed %b required an expectation entry", obs);
      end else begin
         ex  = exp_q.pop_front();
         tag = tag_q.pop_front();
         assert (obs === ex) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, ex);
         end
      end
   endtask

   task automatic run_all();
      while (exp_q.size() > 0) step();
   endtask

   // Accept a start for one cycle, then let the sequence run out
   task automatic one_shot(int len, int off, int blen, bit en, int iidx, string tag);
      drive_cfg(len, off, blen, en, iidx);
      sif.start = 1'b1;
      push_seq(len, off, blen, en, iidx, 99, tag);
      step();
      sif.start = 1'b0;
      run_all();
   endtask

   initial begin
      // Reset wins over a simultaneous valid start
      rst       = 1'b1;
      sif.start = 1'b1;
      drive_cfg(6, 2, 2, 0, 0);
      push(mk(0, 0, 0, 0, 0, 0), "reset0");
      push(mk(0, 0, 0, 0, 0, 0), "reset1");
      step();
      step();
      rst       = 1'b0;
      sif.start = 1'b0;
      push(mk(0, 0, 0, 0, 0, 0), "post_reset");
      step();

      // Basic window, no dropout
      one_shot(6, 2, 2, 0, 0, "basic");
      // Dropout inside the bus window
      one_shot(6, 2, 2, 1, 3, "inject");

      // Rejected configurations
      drive_cfg(4, 3, 2, 0, 0);
      sif.start = 1'b1;
      push_reject("rej_sum");
      step();
      sif.start = 1'b0;
      run_all();
      drive_cfg(4, 0, 0, 0, 0);
      sif.start = 1'b1;
      push_reject("rej_blen0");
      step();
      sif.start = 1'b0;
      run_all();
      drive_cfg(0, 0, 1, 0, 0);
      sif.start = 1'b1;
      push_reject("rej_len0");
      step();
      sif.start = 1'b0;
      run_all();

      // bus spans the whole train
      one_shot(5, 0, 5, 0, 0, "full_bus");
      // bus ends together with train
      one_shot(6, 4, 2, 0, 0, "bus_tail");
      // dropout index out of range
      one_shot(6, 1, 2, 1, 9, "inj_oor");
      // maximum train length with dropout on the last index
      one_shot(15, 14, 1, 1, 14, "max_len");

      // Start while busy is ignored and config changes do not disturb the run
      drive_cfg(6, 1, 3, 1, 4);
      sif.start = 1'b1;
      push_seq(6, 1, 3, 1, 4, 99, "busy_ign");
      step();
      sif.start = 1'b0;
      step();
      drive_cfg(1, 0, 1, 0, 0);
      sif.start = 1'b1;
      step();
      drive_cfg(4, 3, 2, 0, 0);   // would be rejected if sampled
      step();
      sif.start = 1'b0;
      run_all();

      // Reset on TRAIN index 2 aborts without done
      drive_cfg(6, 2, 2, 0, 0);
      sif.start = 1'b1;
      push_seq(6, 2, 2, 0, 0, 4, "abort");
      push(mk(0, 0, 0, 0, 0, 0), "abort_rst");
      step();
      sif.start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      push(mk(0, 0, 0, 0, 0, 0), "abort_rel");
      step();
      one_shot(6, 0, 1, 0, 0, "after_rst");

      // start held high: back-to-back sequences with one IDLE cycle between
      drive_cfg(1, 0, 1, 0, 0);
      sif.start = 1'b1;
      push_seq(1, 0, 1, 0, 0, 99, "hold_a");
      push_seq(1, 0, 1, 0, 0, 99, "hold_b");
      push_seq(1, 0, 1, 0, 0, 99, "hold_c");
      for (int n = 0; n < 11; n++) step();
      sif.start = 1'b0;
      push(mk(0, 0, 0, 0, 0, 0), "hold_end");
      run_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule : tb_within_stim_gen
`default_nettype wire

// File: doc/within_stim_gen.md
WITHIN_STIM_GEN -- requirements
Module: within_stim_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, setting the width of all length, offset and index fields.
REQ-002 Port clk, input, 1 bit: single clock; all logic SHALL be on posedge clk.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request one window sequence; sampled only in IDLE.
REQ-005 Port train_len, input, CNT_W bits: number of cycles train is high.
REQ-006 Port bus_off, input, CNT_W bits: train-relative cycle index where bus rises.
REQ-007 Port bus_len, input, CNT_W bits: number of cycles bus is high.
REQ-008 Port inj_en, input, 1 bit: enables injection of a transport dropout.
REQ-009 Port inj_idx, input, CNT_W bits: train-relative cycle index of the transport dropout.
REQ-010 Ports transport, bus and train, outputs, 1 bit each: registered stimulus to the downstream throughout/within checker.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-013 Port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-014 The FSM SHALL have states IDLE, LEAD, TRAIN and DONE.
REQ-015 In IDLE with start=1, config SHALL be latched and the next state SHALL be LEAD, subject to REQ-016.
REQ-016 Start SHALL be rejected when any of these holds: train_len=0, bus_len=0, or bus_off+bus_len > train_len.
- The sum SHALL be computed in CNT_W+1 bits so it cannot wrap.
- On rejection, cfg_err SHALL pulse the next cycle and the state SHALL remain IDLE.
REQ-017 LEAD SHALL last exactly one cycle, with transport=1, train=0 and bus=0, then go to TRAIN.
REQ-018 TRAIN SHALL last exactly train_len cycles, using index i = 0 .. train_len-1.
- train=1 throughout.
- bus=1 only for bus_off <= i <= bus_off+bus_len-1.
- transport=1, except transport=0 when inj_en=1 and i=inj_idx.
REQ-019 If inj_idx >= train_len, no dropout SHALL occur.
REQ-020 DONE SHALL last one cycle with transport, bus and train all 0 and done=1, then go to IDLE.
REQ-021 Total latency from start accepted to the done pulse SHALL be train_len+2 cycles.
REQ-022 Start while busy=1 SHALL be ignored, with no cfg_err and no config change.
REQ-023 Config inputs SHALL be sampled only at the accepted start; later changes SHALL have no effect on the running sequence.
REQ-024 bus_off+bus_len = train_len SHALL be legal: bus falls in the same cycle as train.
REQ-025 train_len = 2^CNT_W-1 SHALL be legal, and the index counter SHALL NOT wrap.
REQ-026 Start in the cycle DONE returns to IDLE SHALL NOT be sampled; it is sampled from the first IDLE cycle onward.

Reset
REQ-027 With rst=1 at a clock edge, the next state SHALL be IDLE.
- transport, bus, train, busy, done and cfg_err SHALL be 0.
- The counter and latched config SHALL be 0.
REQ-028 Reset SHALL take priority over start in the same cycle.
REQ-029 Reset mid-sequence SHALL abort the sequence, force all outputs to 0 the next cycle, and produce no done pulse.

Structure
REQ-030 Package within_stim_pkg SHALL hold the state enum (2 bits) and the CNT_W default constant.
REQ-031 The block SHALL be a single module with no sub-module; all outputs SHALL be registered.

Verification
REQ-032 Scenario: train_len=6, bus_off=2, bus_len=2, inj_en=0, then start.
- transport high 7 cycles; train high 6; bus high 2, starting 3 cycles after transport rises.
- done 8 cycles after start; downstream assertion passes.
REQ-033 Scenario: same config, inj_en=1, inj_idx=3.
- transport low for exactly one cycle while bus=1; downstream assertion fails at that cycle.
REQ-034 Scenario: train_len=4, bus_off=3, bus_len=2.
- cfg_err pulses once; busy stays 0; transport, bus and train stay 0.
REQ-035 Scenario: train_len=5, bus_off=0, bus_len=5.
- bus and train rise and fall on identical cycles; done at start+7.
REQ-036 Scenario: start, then rst asserted on TRAIN index 2.
- All outputs 0 the next cycle; no done pulse.
- A new start 1 cycle after reset release is accepted normally.
REQ-037 Scenario: start held high continuously with train_len=1, bus_off=0, bus_len=1.
- Back-to-back sequences, each exactly 3 busy cycles; the retrigger start is first sampled the cycle after DONE.
